// File: rtl/manchester_pkg.sv
// Shared types and helpers for the Manchester line encoder.
// Holds the encoder FSM states, the line-convention constants and the
// half-bit length helper used when a symbol is loaded from the FIFO.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    // Line convention selected by cfg_ieee.
    localparam logic MANCH_THOMAS = 1'b0;   // first half carries the data level
    localparam logic MANCH_IEEE   = 1'b1;   // first half carries the inverted data level

    // Half-bit length in clock cycles: the pulse width with its LSB dropped, plus one,
    // so pw=0 and pw=1 both give a one-cycle half.
    function automatic logic [31:0] half_len(input logic [31:0] pw);
        return (pw >> 1) + 32'd1;
    endfunction

endpackage

// File: rtl/manchester_sync_fifo.sv
// Purpose: first-word fall-through synchronous FIFO with registered storage.
// Latency: a pushed word is visible on rd_data the cycle after the push edge.
// Backpressure: full blocks pushes, empty blocks pops; same-cycle push and pop both happen.
module manchester_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal means empty, differing only in the wrap bit means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Advance the pointers; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data-only and needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/manchester_encoder_fifo.sv
// Purpose: buffers {pulse width, bit} entries and drives them as gapless Manchester symbols.
// Latency: a bit pushed into an empty, idle block drives the line on the following edge.
// Backpressure: in_ready = !full (a same-cycle pop does not open a slot); source holds in_valid.
module manchester_encoder_fifo
    import manchester_pkg::*;
#(
    parameter int PW_WIDTH = 6,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_data,
    input  logic [PW_WIDTH-1:0] in_pulsewidth,
    input  logic                cfg_ieee,
    output logic                out_data,
    output logic                out_enable,
    output logic                busy
);

    localparam int EW = PW_WIDTH + 1;

    logic [EW-1:0]       wr_entry;
    logic [EW-1:0]       rd_entry;
    logic [PW_WIDTH-1:0] rd_pw;
    logic                rd_bit;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [PW_WIDTH-1:0] head_half_m1;
    logic                head_level;

    state_t              state;
    logic [PW_WIDTH-1:0] cnt;
    logic [PW_WIDTH-1:0] half_m1;

    assign wr_entry = {in_pulsewidth, in_data};
    assign rd_pw    = rd_entry[EW-1:1];
    assign rd_bit   = rd_entry[0];

    assign in_ready = !full;
    assign push     = in_valid && !full;

    // A symbol is taken from the FIFO when idle, or at the very last cycle of a
    // second half so the next symbol follows with no idle cycle in between.
    assign pop = !empty && ((state == IDLE) || ((state == SECOND) && (cnt == '0)));

    assign busy = (state != IDLE) || !empty;

    // Counter reload value (H-1) and first-half level for the entry at the FIFO head.
    assign head_half_m1 = PW_WIDTH'(half_len(32'(rd_pw)) - 32'd1);
    assign head_level   = (cfg_ieee == MANCH_IEEE) ? ~rd_bit : rd_bit;

    manchester_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    // Symbol FSM: first half, then the inverted second half, each H cycles long.
    // The half length is latched at pop because the FIFO head moves on immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            half_m1    <= '0;
            out_data   <= 1'b0;
            out_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_enable <= 1'b1;
                        out_data   <= head_level;
                        cnt        <= head_half_m1;
                        half_m1    <= head_half_m1;
                        state      <= FIRST;
                    end
                end
                FIRST: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        out_data <= ~out_data;
                        cnt      <= half_m1;
                        state    <= SECOND;
                    end
                end
                SECOND: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (pop) begin
                        out_data <= head_level;
                        cnt      <= head_half_m1;
                        half_m1  <= head_half_m1;
                        state    <= FIRST;
                    end else begin
                        out_enable <= 1'b0;
                        out_data   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
